// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-ported register file: default geometry,
// the register index type and the helper that locates port k in a packed bus.
package regfile_pkg;

   localparam int DEF_ADDR_WIDTH = 5;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_NUM_RD     = 2;
   localparam int DEF_NUM_WR     = 1;

   typedef logic [DEF_ADDR_WIDTH-1:0] reg_idx_t;

   // LSB position of port k inside a packed bus whose ports are 'width' bits wide.
   function automatic int unsigned slice_lsb(input int unsigned k, input int unsigned width);
      return k * width;
   endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Per-register write resolution: turns NUM_WR independent write ports into
// one enable/data pair per register. When several ports hit the same register
// the highest port index wins; writes to register 0 are dropped when it is
// hardwired to zero. Used both for array update and for the read bypass.
module regfile_wr_arb
   import regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_WR     = DEF_NUM_WR,
   parameter int ZERO_REG   = 1
) (
   input  logic [NUM_WR-1:0]            wen,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
   input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
   output logic [2**ADDR_WIDTH-1:0]     reg_we,
   output logic [DATA_WIDTH-1:0]        reg_wdata [2**ADDR_WIDTH]
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_reg
         logic                  we_sel;
         logic [DATA_WIDTH-1:0] wd_sel;

         // Scan ports in ascending order so a later (higher) port overrides.
         always_comb begin
            we_sel = 1'b0;
            wd_sel = '0;
            for (int k = 0; k < NUM_WR; k++) begin
               if (wen[k] && (waddr[slice_lsb(k, ADDR_WIDTH) +: ADDR_WIDTH] == ADDR_WIDTH'(gi))) begin
                  we_sel = 1'b1;
                  wd_sel = wdata[slice_lsb(k, DATA_WIDTH) +: DATA_WIDTH];
               end
            end
            if ((ZERO_REG != 0) && (gi == 0)) begin
               we_sel = 1'b0;
               wd_sel = '0;
            end
         end

         assign reg_we[gi]    = we_sel;
         assign reg_wdata[gi] = wd_sel;
      end
   endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported architectural register file with valid/busy tracking.
// Data array is never reset; valid[] masks stale contents after reset and
// busy[] is the issue/writeback scoreboard. Reads are combinational, with an
// optional same-cycle forward of resolved write data.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_RD     = DEF_NUM_RD,
   parameter int NUM_WR     = DEF_NUM_WR,
   parameter int BYPASS     = 1,
   parameter int ZERO_REG   = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_WR-1:0]            wen,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
   input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
   input  logic                         ren,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
   output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
   output logic [NUM_RD-1:0]            rbusy,
   input  logic                         set_busy,
   input  logic [ADDR_WIDTH-1:0]        set_addr,
   input  logic [ADDR_WIDTH-1:0]        dbg_addr,
   output logic [DATA_WIDTH-1:0]        dbg_data
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
   logic [DEPTH-1:0]      valid_reg;
   logic [DEPTH-1:0]      valid_next;
   logic [DEPTH-1:0]      busy_reg;
   logic [DEPTH-1:0]      busy_next;
   logic [DEPTH-1:0]      set_hit;
   logic [DEPTH-1:0]      reg_we;
   logic [DATA_WIDTH-1:0] reg_wdata [DEPTH];

   regfile_wr_arb #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_WR     (NUM_WR),
      .ZERO_REG   (ZERO_REG)
   ) u_wr_arb (
      .wen       (wen),
      .waddr     (waddr),
      .wdata     (wdata),
      .reg_we    (reg_we),
      .reg_wdata (reg_wdata)
   );

   // Data array update; no reset, stale contents are hidden by valid_reg.
   always_ff @(posedge clk) begin
      for (int r = 0; r < DEPTH; r++) begin
         if (reg_we[r]) begin
            mem_reg[r] <= reg_wdata[r];
         end
      end
   end

   // Decode the issue-side busy set; register 0 never becomes busy when hardwired.
   always_comb begin
      set_hit = '0;
      if (set_busy && !((ZERO_REG != 0) && (set_addr == '0))) begin
         set_hit[set_addr] = 1'b1;
      end
   end

   // Writes validate and clear busy; a same-cycle set overrides the clear.
   always_comb begin
      valid_next = valid_reg | reg_we;
      busy_next  = set_hit | (busy_reg & ~reg_we);
   end

   // Valid and busy state, cleared asynchronously so reads mask immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_reg <= '0;
         busy_reg  <= '0;
      end else begin
         valid_reg <= valid_next;
         busy_reg  <= busy_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_WIDTH-1:0] ra;
         logic [DATA_WIDTH-1:0] rd;

         assign ra = raddr[slice_lsb(gi, ADDR_WIDTH) +: ADDR_WIDTH];

         // Read mux: global enable, zero register, forwarded write, then stored value.
         always_comb begin
            rd = '0;
            if (ren && !((ZERO_REG != 0) && (ra == '0))) begin
               if ((BYPASS != 0) && reg_we[ra]) begin
                  rd = reg_wdata[ra];
               end else if (valid_reg[ra]) begin
                  rd = mem_reg[ra];
               end
            end
         end

         assign rdata[slice_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] = rd;
         assign rbusy[gi] = busy_reg[ra];
      end
   endgenerate

   // Debug port shows committed contents only, independent of ren and bypass.
   always_comb begin
      dbg_data = '0;
      if (valid_reg[dbg_addr] && !((ZERO_REG != 0) && (dbg_addr == '0))) begin
         dbg_data = mem_reg[dbg_addr];
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances sharing every input, one with bypass and
// one without, both with two write and two read ports. Directed vector table,
// hand sequence for asynchronous reset, then random traffic against a model.
module tb_regfile_mp;

   logic        clk;
   logic        rst;
   logic [1:0]  wen;
   logic [9:0]  waddr;
   logic [63:0] wdata;
   logic        ren;
   logic [9:0]  raddr;
   logic [63:0] rdata_bp, rdata_nb;
   logic [1:0]  rbusy_bp, rbusy_nb;
   logic        set_busy;
   logic [4:0]  set_addr;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_bp, dbg_nb;

   int checks   = 0;
   int failures = 0;

   regfile_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .ZERO_REG(1)) dut_bp (
      .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .ren(ren), .raddr(raddr),
      .rdata(rdata_bp), .rbusy(rbusy_bp), .set_busy(set_busy), .set_addr(set_addr),
      .dbg_addr(dbg_addr), .dbg_data(dbg_bp)
   );

   regfile_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0), .ZERO_REG(1)) dut_nb (
      .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .ren(ren), .raddr(raddr),
      .rdata(rdata_nb), .rbusy(rbusy_nb), .set_busy(set_busy), .set_addr(set_addr),
      .dbg_addr(dbg_addr), .dbg_data(dbg_nb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   logic [31:0] m_mem   [32];
   bit          m_valid [32];
   bit          m_busy  [32];

   function automatic void m_reset();
      for (int r = 0; r < 32; r++) begin
         m_valid[r] = 0;
         m_busy[r]  = 0;
      end
   endfunction

   // Architectural effect of one clock edge with the current inputs.
   function automatic void m_edge();
      logic [4:0] a;
      for (int k = 0; k < 2; k++) begin
         a = waddr[k*5 +: 5];
         if (wen[k] && a != 0) begin
            m_mem[a]   = wdata[k*32 +: 32];
            m_valid[a] = 1;
            m_busy[a]  = 0;
         end
      end
      if (set_busy && set_addr != 0) m_busy[set_addr] = 1;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a, input bit bp);
      if (!ren || a == 0) return 32'h0;
      if (bp) begin
         if (wen[1] && waddr[9:5] == a) return wdata[63:32];
         if (wen[0] && waddr[4:0] == a) return wdata[31:0];
      end
      return m_valid[a] ? m_mem[a] : 32'h0;
   endfunction

   function automatic logic [31:0] m_dbg(input logic [4:0] a);
      return (a != 0 && m_valid[a]) ? m_mem[a] : 32'h0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_vs_model(input string tag);
      for (int p = 0; p < 2; p++) begin
         chk($sformatf("%s rd_bp%0d", tag, p), rdata_bp[p*32 +: 32], m_read(raddr[p*5 +: 5], 1));
         chk($sformatf("%s rd_nb%0d", tag, p), rdata_nb[p*32 +: 32], m_read(raddr[p*5 +: 5], 0));
         chk($sformatf("%s busy_bp%0d", tag, p), 32'(rbusy_bp[p]), 32'(m_busy[raddr[p*5 +: 5]]));
         chk($sformatf("%s busy_nb%0d", tag, p), 32'(rbusy_nb[p]), 32'(m_busy[raddr[p*5 +: 5]]));
      end
      chk($sformatf("%s dbg_bp", tag), dbg_bp, m_dbg(dbg_addr));
      chk($sformatf("%s dbg_nb", tag), dbg_nb, m_dbg(dbg_addr));
   endtask

   // Let the edge happen with the current inputs, mirror it in the model,
   // and return at the following falling edge ready for new stimulus.
   task automatic clock_edge();
      @(posedge clk);
      if (rst) m_edge();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      wen = 2'b00; waddr = '0; wdata = '0; set_busy = 1'b0; set_addr = '0;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [1:0]  wen;
      logic [4:0]  wa0, wa1;
      logic [31:0] wd0, wd1;
      logic        ren;
      logic [4:0]  ra0, ra1;
      logic        sb;
      logic [4:0]  sa;
      logic [4:0]  da;
      logic [31:0] e_rd0, e_rd1, e_nb0;
      logic        e_busy0;
      logic [31:0] e_dbg;
   } vec_t;

   function automatic vec_t mkv(
      input logic [1:0] w, input logic [4:0] a0, input logic [31:0] d0,
      input logic [4:0] a1, input logic [31:0] d1, input logic re,
      input logic [4:0] r0, input logic [4:0] r1, input logic sb, input logic [4:0] sa,
      input logic [4:0] da, input logic [31:0] e0, input logic [31:0] e1,
      input logic [31:0] en0, input logic eb, input logic [31:0] ed);
      vec_t v;
      v.wen = w; v.wa0 = a0; v.wd0 = d0; v.wa1 = a1; v.wd1 = d1; v.ren = re;
      v.ra0 = r0; v.ra1 = r1; v.sb = sb; v.sa = sa; v.da = da;
      v.e_rd0 = e0; v.e_rd1 = e1; v.e_nb0 = en0; v.e_busy0 = eb; v.e_dbg = ed;
      return v;
   endfunction

   localparam int NV = 14;
   vec_t vecs [NV];

   initial begin
      //            wen   wa0 wd0            wa1 wd1            ren ra0 ra1 sb sa da  e_rd0          e_rd1         e_nb0          eb e_dbg
      vecs[0]  = mkv(2'b01, 3, 32'h1234,     0, 0,             1,  3,  0,  0, 0, 3,  32'h1234,      32'h0,        32'h0,         0, 32'h0);
      vecs[1]  = mkv(2'b00, 0, 0,            0, 0,             1,  3,  3,  0, 0, 3,  32'h1234,      32'h1234,     32'h1234,      0, 32'h1234);
      vecs[2]  = mkv(2'b11, 7, 32'hAAAA,     7, 32'hBBBB,      1,  7,  3,  0, 0, 7,  32'hBBBB,      32'h1234,     32'h0,         0, 32'h0);
      vecs[3]  = mkv(2'b11, 9, 32'h9999,     8, 32'h8888,      1,  7,  8,  0, 0, 7,  32'hBBBB,      32'h8888,     32'hBBBB,      0, 32'hBBBB);
      vecs[4]  = mkv(2'b00, 0, 0,            0, 0,             1,  9,  8,  0, 0, 8,  32'h9999,      32'h8888,     32'h9999,      0, 32'h8888);
      vecs[5]  = mkv(2'b01, 0, 32'hFFFFFFFF, 0, 0,             1,  0,  0,  1, 0, 0,  32'h0,         32'h0,        32'h0,         0, 32'h0);
      vecs[6]  = mkv(2'b00, 0, 0,            0, 0,             1,  0,  9,  1, 4, 0,  32'h0,         32'h9999,     32'h0,         0, 32'h0);
      vecs[7]  = mkv(2'b01, 4, 32'h44,       0, 0,             1,  4,  9,  1, 4, 4,  32'h44,        32'h9999,     32'h0,         1, 32'h0);
      vecs[8]  = mkv(2'b01, 4, 32'h55,       0, 0,             1,  4,  8,  0, 0, 4,  32'h55,        32'h8888,     32'h44,        1, 32'h44);
      vecs[9]  = mkv(2'b00, 0, 0,            0, 0,             1,  4,  7,  0, 0, 4,  32'h55,        32'hBBBB,     32'h55,        0, 32'h55);
      vecs[10] = mkv(2'b01, 2, 32'h22,       0, 0,             0,  2,  9,  0, 0, 3,  32'h0,         32'h0,        32'h0,         0, 32'h1234);
      vecs[11] = mkv(2'b00, 0, 0,            0, 0,             1,  2,  3,  0, 0, 2,  32'h22,        32'h1234,     32'h22,        0, 32'h22);
      vecs[12] = mkv(2'b10, 0, 0,            31, 32'hCAFEF00D, 1,  31, 31, 0, 0, 31, 32'hCAFEF00D,  32'hCAFEF00D, 32'h0,         0, 32'h0);
      vecs[13] = mkv(2'b00, 0, 0,            0, 0,             1,  31, 0,  0, 0, 31, 32'hCAFEF00D,  32'h0,        32'hCAFEF00D,  0, 32'hCAFEF00D);
   end

   // ---------------- test sequence ----------------
   initial begin
      rst = 1'b0;
      idle_inputs();
      ren = 1'b1; raddr = '0; dbg_addr = '0;
      m_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Reset state
      raddr = {5'd1, 5'd5}; dbg_addr = 5'd5;
      #1;
      chk("reset rd0", rdata_bp[31:0], 32'h0);
      chk("reset rd1", rdata_nb[63:32], 32'h0);
      chk("reset busy", 32'(rbusy_bp), 32'h0);
      chk("reset dbg", dbg_bp, 32'h0);
      $display("reset state checked");
      clock_edge();

      // Directed table
      for (int i = 0; i < NV; i++) begin
         wen = vecs[i].wen;
         waddr = {vecs[i].wa1, vecs[i].wa0};
         wdata = {vecs[i].wd1, vecs[i].wd0};
         ren = vecs[i].ren;
         raddr = {vecs[i].ra1, vecs[i].ra0};
         set_busy = vecs[i].sb;
         set_addr = vecs[i].sa;
         dbg_addr = vecs[i].da;
         #1;
         chk($sformatf("vec%0d rd_bp0", i), rdata_bp[31:0], vecs[i].e_rd0);
         chk($sformatf("vec%0d rd_bp1", i), rdata_bp[63:32], vecs[i].e_rd1);
         chk($sformatf("vec%0d rd_nb0", i), rdata_nb[31:0], vecs[i].e_nb0);
         chk($sformatf("vec%0d busy0", i), 32'(rbusy_bp[0]), 32'(vecs[i].e_busy0));
         chk($sformatf("vec%0d busy_nb0", i), 32'(rbusy_nb[0]), 32'(vecs[i].e_busy0));
         chk($sformatf("vec%0d dbg", i), dbg_bp, vecs[i].e_dbg);
         $display("vec %0d wen=%b ra0=%0d ra1=%0d rd0=%h rd1=%h nb0=%h busy0=%b dbg=%h",
                  i, wen, vecs[i].ra0, vecs[i].ra1, rdata_bp[31:0], rdata_bp[63:32],
                  rdata_nb[31:0], rbusy_bp[0], dbg_bp);
         clock_edge();
      end
      idle_inputs();

      // Asynchronous reset in the middle of a cycle
      ren = 1'b1;
      wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEADBEEF};
      set_busy = 1'b1; set_addr = 5'd5;
      raddr = {5'd5, 5'd5}; dbg_addr = 5'd5;
      #1;
      chk("rst_seq bypass r5", rdata_bp[31:0], 32'hDEADBEEF);
      clock_edge();
      idle_inputs();
      #1;
      chk("rst_seq pre r5", rdata_nb[31:0], 32'hDEADBEEF);
      chk("rst_seq pre busy", 32'(rbusy_bp[0]), 32'h1);
      chk("rst_seq pre dbg", dbg_bp, 32'hDEADBEEF);
      #2 rst = 1'b0;
      #1;
      m_reset();
      chk("rst_seq in rd_bp", rdata_bp[31:0], 32'h0);
      chk("rst_seq in rd_nb", rdata_nb[31:0], 32'h0);
      chk("rst_seq in busy", 32'(rbusy_bp[0]), 32'h0);
      chk("rst_seq in dbg", dbg_bp, 32'h0);
      // A write and a busy set while reset is held must be lost.
      wen = 2'b01; waddr = {5'd0, 5'd6}; wdata = {32'h0, 32'h66};
      set_busy = 1'b1; set_addr = 5'd6;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      raddr = {5'd6, 5'd5}; dbg_addr = 5'd6;
      #1;
      chk("rst_seq post r5", rdata_bp[31:0], 32'h0);
      chk("rst_seq post r6", rdata_bp[63:32], 32'h0);
      chk("rst_seq post busy6", 32'(rbusy_bp[1]), 32'h0);
      chk("rst_seq post dbg6", dbg_bp, 32'h0);
      $display("async reset sequence checked");
      clock_edge();

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         wen = 2'($urandom_range(0, 3));
         for (int p = 0; p < 2; p++) begin
            waddr[p*5 +: 5] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            raddr[p*5 +: 5] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wdata[p*32 +: 32] = $urandom;
         end
         ren = ($urandom_range(0, 9) != 0);
         set_busy = ($urandom_range(0, 2) == 0);
         set_addr = 5'($urandom_range(0, 7));
         dbg_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         #1;
         check_vs_model($sformatf("rnd%0d", n));
         $display("rnd %0d wen=%b wa=%h ra=%h ren=%b sb=%b sa=%0d rd=%h busy=%b dbg=%h",
                  n, wen, waddr, raddr, ren, set_busy, set_addr, rdata_bp, rbusy_bp, dbg_bp);
         clock_edge();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Multi-ported, parametrised architectural register file: the next-generation replacement for the single-write, dual-read core register file. Provides NUM_RD read ports and NUM_WR write ports and an optional same-cycle write-to-read bypass. It also adds a per-register busy scoreboard, set at issue and cleared at writeback, plus a debug read port used by the simulation harness. Sits between decode/issue (reads, busy set) and writeback (writes, busy clear).

## Interface
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 32, register width
- NUM_RD, 2, read ports (1..4)
- NUM_WR, 1, write ports (1..2)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = write visible next cycle
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never busy
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; one clock; asynchronous, active-low
- wen  in  NUM_WR  per-port write enable
- waddr  in  NUM_WR*ADDR_WIDTH  packed write addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- wdata  in  NUM_WR*DATA_WIDTH  packed write data
- ren  in  1  global read enable; 0 forces all rdata to 0
- raddr  in  NUM_RD*ADDR_WIDTH  packed read addresses
- rdata  out  NUM_RD*DATA_WIDTH  packed read data, combinational
- rbusy  out  NUM_RD  busy bit of each raddr, combinational
- set_busy  in  1  mark set_addr busy (issue)
- set_addr  in  ADDR_WIDTH  register to mark busy
- dbg_addr  in  ADDR_WIDTH  debug read address
- dbg_data  out  DATA_WIDTH  debug read data, ignores ren and bypass

## Operation
- Storage: data array (not reset), valid[] and busy[] bit vectors (reset).
- Read value of reg r: 0 if ren=0; 0 if ZERO_REG and r=0; 0 if valid[r]=0; else array[r]. With BYPASS=1 a same-cycle write to r (after conflict resolution) overrides the array value and counts as valid.
- Write: wen[k] writes wdata[k] to array[waddr[k]], sets valid, clears busy. ZERO_REG and waddr=0: write dropped, no state change.
- Write conflict (NUM_WR=2, same address, both enabled): higher port index wins; the lower port is discarded entirely.
- Busy: set_busy sets busy[set_addr]. Same-cycle set and write-clear of the same reg: set wins (new producer issued). set_addr=0 with ZERO_REG ignored.
- rbusy reflects registered busy only (no forwarding of same-cycle set/clear).
- dbg_data: registered contents only; 0 for reg 0 (ZERO_REG) or invalid reg.

## Timing
- Reset (rst=0, async): valid[] and busy[] cleared immediately; hence all rdata=0, rbusy=0, dbg_data=0 while in and after reset until written. Array contents undefined but masked. Writes/sets in a reset cycle are lost.
- Read latency 0 (combinational). Write latency: BYPASS=1 visible same cycle on rdata, next cycle on dbg_data; BYPASS=0 visible next cycle on both.
- Busy set/clear: visible on rbusy the cycle after the edge.
- Release of rst is synchronised by the instantiating top; block needs no internal sync.

## Structure
- Package regfile_pkg: default widths, packed-slice helper functions for port k, reg index type.
- One sub-module: regfile_wr_arb, resolves per-register write enable/data across NUM_WR ports (highest index wins, zero-reg drop); reused by the bypass mux.
- Scoreboard logic stays inline.

## Test plan
- Reset mid-run: write 0xDEADBEEF to r5, assert rst low mid-cycle -> rdata for r5 and dbg_data 0 immediately, rbusy 0; after release read r5 = 0.
- Write/read with BYPASS=1: wen[0], waddr=3, wdata=0x1234 while raddr[0]=3 -> rdata[0]=0x1234 same cycle; BYPASS=0 -> 0 that cycle, 0x1234 next.
- Zero register: write 0xFFFFFFFF to r0, set_busy r0 -> read r0 = 0, rbusy 0, dbg_data 0.
- Write conflict (NUM_WR=2): port0 writes 0xAAAA and port1 writes 0xBBBB to r7 -> r7 reads 0xBBBB; a port1 write to r8 and port0 write to r9 in the same cycle -> both land.
- Scoreboard: set_busy r4 -> rbusy=1 next cycle; write r4 with set_busy r4 same cycle -> r4 updated, busy stays 1; plain write r4 next -> busy 0.
- ren=0 with valid data in r2 -> all rdata 0; dbg_data on r2 still returns stored value.
